// File: rtl/doldur_pkg.sv
// Shared constants and types for the doldur word-packing fill register.
package doldur_pkg;

    localparam int DATA_W_D      = 32;
    localparam int DEPTH_WORDS_D = 2;
    localparam int CNT_W_D       = $clog2(DEPTH_WORDS_D + 1);

    typedef logic [CNT_W_D-1:0] cnt_t;

endpackage

// File: rtl/doldur_cnt.sv
// Saturating fill counter with synchronous clear; full decoded from the count.
module doldur_cnt
    import doldur_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_D,
    parameter int CNT_W       = $clog2(DEPTH_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign full = (count == MAX);

endmodule

// File: rtl/doldur_fill.sv
// Word-packing fill register: newest word enters the low end of depo.
// Optional DOLDUR_HOLD_WHEN_FULL_EN freezes depo when full and reports drops.
module doldur_fill
    import doldur_pkg::*;
#(
    parameter int DATA_W      = DATA_W_D,
    parameter int DEPTH_WORDS = DEPTH_WORDS_D,
    parameter int CNT_W       = $clog2(DEPTH_WORDS + 1),
    localparam int DEPO_W     = DATA_W * DEPTH_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] veri,
    output logic [DEPO_W-1:0] depo,
    output logic [CNT_W-1:0]  count,
`ifdef DOLDUR_HOLD_WHEN_FULL_EN
    output logic              full,
    output logic              drop
`else
    output logic              full
`endif
);

    logic accept;

`ifdef DOLDUR_HOLD_WHEN_FULL_EN
    assign accept = in_valid && !full;

    // A word offered while full is lost; flag it for one cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            drop <= 1'b0;
        end else begin
            drop <= in_valid && full;
        end
    end
`else
    assign accept = in_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            depo <= '0;
        end else if (accept) begin
            depo <= {depo[DEPO_W-DATA_W-1:0], veri};
        end
    end

    doldur_cnt #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .CNT_W       (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (accept),
        .count (count),
        .full  (full)
    );

endmodule

// File: tb/tb_doldur_fill.sv
// Scoreboard bench for doldur_fill: stimulus queues expectations, monitor checks.
module tb_doldur_fill;
    import doldur_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] veri = '0;
    logic [63:0] depo;
    cnt_t        count;
    logic        full;
    logic        drop;

    doldur_fill dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .veri     (veri),
        .depo     (depo),
        .count    (count),
`ifdef DOLDUR_HOLD_WHEN_FULL_EN
        .full     (full),
        .drop     (drop)
`else
        .full     (full)
`endif
    );

`ifndef DOLDUR_HOLD_WHEN_FULL_EN
    assign drop = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] depo;
        logic [1:0]  cnt;
        logic        full;
        logic        drop;
        string       name;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    // Drive one edge; the expected post-edge state is queued after the edge.
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [31:0] w, input logic [63:0] ed,
                        input logic [1:0] ec, input logic ef,
                        input logic edr, input string nm);
        exp_t e;
        rst = r;
        clr = c;
        in_valid = v;
        veri = w;
        @(posedge clk);
        #1;
        e.depo = ed;
        e.cnt = ec;
        e.full = ef;
        e.drop = edr;
        e.name = nm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic bad;
            e = q.pop_front();
            compared++;
            bad = (depo !== e.depo) || (count !== e.cnt) || (full !== e.full);
`ifdef DOLDUR_HOLD_WHEN_FULL_EN
            bad = bad || (drop !== e.drop);
`endif
            if (bad) begin
                mismatched++;
                $display("FAIL %s: got depo=%h count=%0d full=%b drop=%b, want depo=%h count=%0d full=%b drop=%b",
                         e.name, depo, count, full, drop,
                         e.depo, e.cnt, e.full, e.drop);
            end
        end
    end

    initial begin
        logic [63:0] ed;
        logic [1:0]  ec;
        logic        ef;
        logic        edr;

        step(1, 0, 1, 32'hFFFF_FFFF, 64'h0, 0, 0, 0, "reset0");
        step(1, 0, 1, 32'hFFFF_FFFF, 64'h0, 0, 0, 0, "reset1");

        step(0, 0, 1, 32'h1111_1111, 64'h0000_0000_1111_1111, 1, 0, 0, "fill1");
        step(0, 0, 1, 32'h2222_2222, 64'h1111_1111_2222_2222, 2, 1, 0, "fill2");

        step(0, 1, 1, 32'hABCD_0123, 64'h0, 0, 0, 0, "clr_prio");

        for (int k = 1; k <= 14; k++) begin
            if (k == 1) begin
                ed = 64'h0000_0000_0000_0001;
                ec = 1;
                ef = 0;
                edr = 0;
            end else begin
`ifdef DOLDUR_HOLD_WHEN_FULL_EN
                ed = 64'h0000_0001_0000_0002;
                edr = (k >= 3);
`else
                ed = {32'(k - 1), 32'(k)};
                edr = 0;
`endif
                ec = 2;
                ef = 1;
            end
            step(0, 0, 1, 32'(k), ed, ec, ef, edr, $sformatf("slide%0d", k));
        end

        step(1, 0, 1, 32'h5555_5555, 64'h0, 0, 0, 0, "rst_prio");

        step(0, 0, 1, 32'h0000_00A0, 64'h0000_0000_0000_00A0, 1, 0, 0, "gap_v0");
        step(0, 0, 0, 32'h0000_00A1, 64'h0000_0000_0000_00A0, 1, 0, 0, "gap_i1");
        step(0, 0, 1, 32'h0000_00A2, 64'h0000_00A0_0000_00A2, 2, 1, 0, "gap_v2");
        step(0, 0, 0, 32'h0000_00A3, 64'h0000_00A0_0000_00A2, 2, 1, 0, "gap_i3");
`ifdef DOLDUR_HOLD_WHEN_FULL_EN
        step(0, 0, 1, 32'h0000_00A4, 64'h0000_00A0_0000_00A2, 2, 1, 1, "gap_v4");
`else
        step(0, 0, 1, 32'h0000_00A4, 64'h0000_00A2_0000_00A4, 2, 1, 0, "gap_v4");
`endif
        step(0, 0, 0, 32'h0000_00A5, 64'h0, 0, 0, 0, "skip");
        q.pop_back();

        step(0, 1, 0, 32'h0, 64'h0, 0, 0, 0, "clr_only");
        step(0, 0, 1, 32'hAAAA_AAAA, 64'h0000_0000_AAAA_AAAA, 1, 0, 0, "hold_a");
        step(0, 0, 1, 32'hBBBB_BBBB, 64'hAAAA_AAAA_BBBB_BBBB, 2, 1, 0, "hold_b");
`ifdef DOLDUR_HOLD_WHEN_FULL_EN
        step(0, 0, 1, 32'hCCCC_CCCC, 64'hAAAA_AAAA_BBBB_BBBB, 2, 1, 1, "hold_c");
        step(0, 0, 0, 32'h0, 64'hAAAA_AAAA_BBBB_BBBB, 2, 1, 0, "hold_idle");
`else
        step(0, 0, 1, 32'hCCCC_CCCC, 64'hBBBB_BBBB_CCCC_CCCC, 2, 1, 0, "hold_c");
        step(0, 0, 0, 32'h0, 64'hBBBB_BBBB_CCCC_CCCC, 2, 1, 0, "hold_idle");
`endif
        step(0, 1, 1, 32'hDDDD_DDDD, 64'h0, 0, 0, 0, "hold_clr");

        in_valid = 0;
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule

// File: doc/doldur_fill.md
Name: doldur_fill

Overview:
- Word-packing fill register: accepts a stream of 32-bit words and packs them into a wide storage register `depo` (default 64 bits = 2 words).
- Each accepted word shifts into the low end; older words move toward the high end.
- Sits between a word-serial source (memory readout, bus) and a wide consumer that samples `depo` once filled.
- Also provides a fill counter and a full flag.

Parameters:
- DATA_W, 32, width of one input word `veri`.
- DEPTH_WORDS, 2, number of words held in `depo`; must be >= 2.
- DEPO_W, DATA_W*DEPTH_WORDS, width of `depo` (derived; not overridden).
- CNT_W, $clog2(DEPTH_WORDS+1), width of `count`.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of contents and count; active-high.
- in_valid  input  1  `veri` is accepted on this edge when high.
- veri  input  DATA_W  input data word.
- depo  output  DEPO_W  packed storage; newest word in [DATA_W-1:0].
- count  output  CNT_W  number of valid words held; saturates at DEPTH_WORDS.
- full  output  1  high when count == DEPTH_WORDS.
- Interface note (already decided): one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- All state updates on the rising edge of `clk`. Outputs are registered (`full` may be decoded combinationally from the `count` register).
- Reset: on an edge with rst=1, depo=0, count=0, full=0. rst has priority over all other inputs.
- Priority per edge: rst > clr > in_valid.
- clr=1 (rst=0): same effect as reset (depo=0, count=0). `veri` is ignored that edge even if in_valid=1.
- Accept (in_valid=1, no rst/clr): depo <= {depo[DEPO_W-DATA_W-1:0], veri}. The oldest word, depo[DEPO_W-1 -: DATA_W], is discarded. count <= min(count+1, DEPTH_WORDS).
- in_valid=0: depo and count hold.
- Latency: a word accepted on edge N is visible in depo[DATA_W-1:0] after edge N. It reaches the top word after DEPTH_WORDS-1 further accepts.
- After k accepts from empty (k < DEPTH_WORDS), the upper DEPO_W-k*DATA_W bits remain 0.
- Full with further accepts (default build): keeps shifting as a sliding window of the last DEPTH_WORDS words. count stays at DEPTH_WORDS; full stays 1.
- No X propagation: `veri` is only sampled when in_valid=1.
- Arithmetic: count is unsigned and saturating; it never wraps.

Optional Feature:
- Macro: DOLDUR_HOLD_WHEN_FULL_EN.
- Defined: when full=1, in_valid is ignored; depo and count freeze until clr or rst. Adds output `drop` (1 bit, registered). `drop` pulses high for one cycle after any edge where in_valid=1 arrived while full=1 and no rst/clr; it resets to 0.
- Undefined: sliding-window behaviour above; no `drop` port.

Decomposition:
- Package doldur_pkg: default DATA_W and DEPTH_WORDS constants, and a count type sized by CNT_W.
- Optional single sub-module doldur_cnt: saturating up-counter with sync clear, producing count and full.
- The shift datapath stays in the top module.

Test Plan:
- Reset: rst=1 for 2 edges with in_valid=1, veri=32'hFFFF_FFFF -> depo=0, count=0, full=0.
- Two-word fill: accept 32'h1111_1111 then 32'h2222_2222 -> depo=64'h1111_1111_2222_2222, count=2, full=1. After the first accept: depo=64'h0000_0000_1111_1111, count=1.
- Sliding stream: accept 14 words 32'h0000_0001..32'h0000_000E consecutively -> depo=64'h0000_000D_0000_000E, count=2. Default build only.
- Hold gaps: alternate in_valid 1/0 with veri changing every cycle -> only valid-cycle words appear; depo is unchanged on idle cycles.
- Clear/priority: clr=1 and in_valid=1 with veri=32'hABCD_0123 on the same edge -> depo=0, count=0. rst=1 and clr=0 on the same edge -> also zero.
- DOLDUR_HOLD_WHEN_FULL_EN: fill with A, B, then accept C -> depo={A,B} unchanged, drop=1 for one cycle. Then clr -> depo=0, count=0, drop=0.
